// File: rtl/xnor_based_ripple_carry_adder16_aor_enc32.sv
// Logic-locked 16-bit ripple-carry adder with 32 key gates on the propagate and carry nets.
// Only the correct key yields A+B; any other key gives a deterministic corrupted sum.
module xnor_based_ripple_carry_adder16_aor_enc32 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] add1_i,
  input  logic [15:0] add2_i,
  input  logic [31:0] keyinput,
  output logic [16:0] result_o
);

  localparam logic [31:0] KEY_CORRECT = 32'h2E798869;

  logic [16:0] carry;
  logic [15:0] prop;
  logic [15:0] prop_key;
  logic [15:0] gen;
  logic [15:0] carry_raw;
  logic [15:0] sum;

  // Key gate is XNOR where the correct key bit is 1, XOR where it is 0,
  // so each gate is transparent only at its correct key value.
  always_comb begin
    carry     = '0;
    prop      = '0;
    prop_key  = '0;
    gen       = '0;
    carry_raw = '0;
    sum       = '0;
    for (int i = 0; i < 16; i++) begin
      prop[i]      = ~(add1_i[i] ~^ add2_i[i]);
      prop_key[i]  = KEY_CORRECT[i] ? (prop[i] ~^ keyinput[i]) : (prop[i] ^ keyinput[i]);
      sum[i]       = prop_key[i] ^ carry[i];
      gen[i]       = add1_i[i] & add2_i[i];
      carry_raw[i] = gen[i] | (prop_key[i] & carry[i]);
      carry[i+1]   = KEY_CORRECT[16+i] ? (carry_raw[i] ~^ keyinput[16+i])
                                       : (carry_raw[i] ^ keyinput[16+i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
    end else begin
      result_o <= {carry[16], sum};
    end
  end

endmodule

// File: tb/tb_xnor_based_ripple_carry_adder16_aor_enc32.sv
// Self-checking bench: directed and randomized steps compared against a bit-level
// reference built from the key-error-vector equations, plus plain A+B for the correct key.
module tb_xnor_based_ripple_carry_adder16_aor_enc32;

  localparam logic [31:0] K0 = 32'h2E798869;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] add1_i;
  logic [15:0] add2_i;
  logic [31:0] keyinput;
  logic [16:0] result_o;

  int checks   = 0;
  int failures = 0;

  xnor_based_ripple_carry_adder16_aor_enc32 dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .add1_i   (add1_i),
    .add2_i   (add2_i),
    .keyinput (keyinput),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: D = K ^ K0 flips propagate bit j (j<16) or carry out of bit j-16 (j>=16).
  function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [31:0] k);
    logic [31:0] d;
    logic [16:0] r;
    bit          c;
    bit          pk;
    d = k ^ K0;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pk   = a[i] ^ b[i] ^ d[i];
      r[i] = pk ^ c;
      c    = ((a[i] & b[i]) | (pk & c)) ^ d[16+i];
    end
    r[16] = c;
    return r;
  endfunction

  task automatic check(input string tag, input logic [16:0] expected);
    checks++;
    assert (result_o === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, result_o, expected);
    end
  endtask

  // Drive at negedge, check just after the following rising edge.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] k, input logic [16:0] expected);
    @(negedge clk_i);
    add1_i   = a;
    add2_i   = b;
    keyinput = k;
    @(posedge clk_i);
    #1;
    check(tag, expected);
  endtask

  logic [15:0] ra;
  logic [15:0] rb;
  logic [31:0] rk;
  logic [31:0] hd_keys [6];

  initial begin
    rst_ni   = 1'b0;
    add1_i   = 16'hFFFF;
    add2_i   = 16'hFFFF;
    keyinput = K0;
    #3;
    check("reset_no_edge", 17'h00000);
    @(posedge clk_i);
    #1;
    check("reset_held", 17'h00000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("release_first_edge", 17'h1FFFE);

    step("ck_ffff_0001", 16'hFFFF, 16'h0001, K0, 17'h10000);
    step("ck_1234_4321", 16'h1234, 16'h4321, K0, 17'h05555);
    step("ck_zero",      16'h0000, 16'h0000, K0, 17'h00000);
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      step("ck_random", ra, rb, K0, {1'b0, ra} + {1'b0, rb});
    end

    step("prop_d0_a1", 16'h0001, 16'h0000, 32'h2E798868, 17'h00000);
    step("prop_d0_a0", 16'h0000, 16'h0000, 32'h2E798868, 17'h00001);
    step("carry_d16",  16'h0000, 16'h0000, 32'h2E788869, 17'h00002);
    step("carry_d28",  16'h0000, 16'h0000, 32'h3E798869, 17'h02000);
    step("carry_d31",  16'h0000, 16'h0000, K0 ^ 32'h8000_0000, 17'h10000);

    hd_keys[0] = 32'h2E798860;
    hd_keys[1] = 32'h2E7988F6;
    hd_keys[2] = 32'hDD798869;
    hd_keys[3] = 32'h2E7EF869;
    hd_keys[4] = K0 ^ 32'h0001_0001;
    hd_keys[5] = K0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        step("key_switch", ra, rb, hd_keys[i], ref_model(ra, rb, hd_keys[i]));
      end
    end
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rk = K0;
      for (int h = 0; h < 1 + (i % 6); h++) rk[$urandom_range(31, 0)] ^= 1'b1;
      step("key_random", ra, rb, rk, ref_model(ra, rb, rk));
    end
    step("key_restored", 16'hABCD, 16'h1357, K0, 17'h0BF24);

    // Asynchronous reset in the middle of a cycle, then recovery.
    step("pre_reset", 16'h8000, 16'h8000, K0, 17'h10000);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset_mid", 17'h00000);
    @(negedge clk_i);
    add1_i   = 16'h0F0F;
    add2_i   = 16'h00F1;
    keyinput = K0;
    rst_ni   = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_reset_sum", 17'h01000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
